// File: rtl/hazard_scheduler_if.sv
// Decode/writeback/MD handshake bundle between the pipeline and the hazard scheduler.
// Pure wiring, no storage, zero latency.
// stall_dec is the only backpressure signal: it holds decode while a hazard is open.
interface hazard_scheduler_if #(
    parameter int PREG_COUNT = 64
);
    localparam int AW = (PREG_COUNT > 1) ? $clog2(PREG_COUNT) : 1;

    logic          dec_valid;
    logic          dec_rs_enable;
    logic          dec_rt_enable;
    logic [AW-1:0] dec_prs_addr;
    logic [AW-1:0] dec_prt_addr;
    logic          dec_wb_reg;
    logic [AW-1:0] dec_write_addr;
    logic [1:0]    dec_exec_src;
    logic          wb_wb_reg;
    logic [AW-1:0] wb_write_addr;
    logic          flush;
    logic          stall_dec;
    logic          md_start;
    logic          md_busy;
    logic [7:0]    pending_count;

    // Pipeline side: drives decode/writeback, receives stall and MD status.
    modport master (
        output dec_valid, dec_rs_enable, dec_rt_enable, dec_prs_addr, dec_prt_addr,
        output dec_wb_reg, dec_write_addr, dec_exec_src, wb_wb_reg, wb_write_addr, flush,
        input  stall_dec, md_start, md_busy, pending_count
    );

    // Scheduler side.
    modport slave (
        input  dec_valid, dec_rs_enable, dec_rt_enable, dec_prs_addr, dec_prt_addr,
        input  dec_wb_reg, dec_write_addr, dec_exec_src, wb_wb_reg, wb_write_addr, flush,
        output stall_dec, md_start, md_busy, pending_count
    );
endinterface

// File: rtl/hazard_scheduler.sv
// Register scoreboard for long-latency writers plus multiply/divide occupancy tracker.
// stall_dec is combinational; scoreboard, md_start and md_busy update one edge after issue.
// Decode is held (stall_dec) on RAW hazards against pending loads/MD results and while MD is busy.
module hazard_scheduler #(
    parameter int PREG_COUNT = 64,
    parameter int MD_LATENCY = 32
) (
    input logic               clk,
    input logic               rst,
    hazard_scheduler_if.slave hs
);
    localparam int AW = (PREG_COUNT > 1) ? $clog2(PREG_COUNT) : 1;

    localparam logic [1:0] EX_ALU = 2'd0;
    localparam logic [1:0] EX_MEM = 2'd1;
    localparam logic [1:0] EX_MD  = 2'd2;

    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

    logic [PREG_COUNT-1:0] r_pending;
    logic [PREG_COUNT-1:0] w_pending_next;
    logic [7:0]            w_pending_count;
    md_state_t             r_md_state;
    logic [7:0]            r_md_cnt;
    logic                  r_md_start;
    logic                  r_md_busy;

    logic w_rs_hazard;
    logic w_rt_hazard;
    logic w_md_hazard;
    logic w_stall;
    logic w_issue;
    logic w_is_md;
    logic w_sets_pending;

    // A writeback in the same cycle already delivers the operand via the bypass path.
    assign w_rs_hazard = hs.dec_rs_enable && r_pending[hs.dec_prs_addr] &&
                         !(hs.wb_wb_reg && (hs.wb_write_addr == hs.dec_prs_addr));
    assign w_rt_hazard = hs.dec_rt_enable && r_pending[hs.dec_prt_addr] &&
                         !(hs.wb_wb_reg && (hs.wb_write_addr == hs.dec_prt_addr));
    assign w_is_md     = (hs.dec_exec_src == EX_MD);
    assign w_md_hazard = w_is_md && r_md_busy;

    assign w_stall = hs.dec_valid && !hs.flush && (w_rs_hazard || w_rt_hazard || w_md_hazard);
    assign w_issue = hs.dec_valid && !w_stall && !hs.flush;

    // ALU results are forwarded, so only loads and MD results need scoreboard tracking.
    assign w_sets_pending = w_issue && hs.dec_wb_reg &&
                            ((hs.dec_exec_src == EX_MEM) || w_is_md) &&
                            (hs.dec_write_addr != '0);

    // Next scoreboard: retire first, then set, so a same-cycle set to the same register wins.
    always_comb begin
        w_pending_next = r_pending;
        if (hs.wb_wb_reg) begin
            w_pending_next[hs.wb_write_addr] = 1'b0;
        end
        if (w_sets_pending) begin
            w_pending_next[hs.dec_write_addr] = 1'b1;
        end
    end

    // Scoreboard register; the clear-on-retire of p0 is harmless because p0 is never set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Population count of the scoreboard, tracking the register with no extra delay.
    always_comb begin
        w_pending_count = 8'd0;
        for (int i = 0; i < PREG_COUNT; i++) begin
            w_pending_count = w_pending_count + 8'(r_pending[i]);
        end
    end

    // MD occupancy FSM: busy for MD_LATENCY cycles starting with the md_start cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_md_state <= S_IDLE;
            r_md_cnt   <= 8'd0;
            r_md_start <= 1'b0;
            r_md_busy  <= 1'b0;
        end else begin
            r_md_start <= 1'b0;
            case (r_md_state)
                S_IDLE: begin
                    if (w_issue && w_is_md) begin
                        r_md_state <= S_BUSY;
                        r_md_cnt   <= MD_LOAD;
                        r_md_start <= 1'b1;
                        r_md_busy  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (r_md_cnt == 8'd0) begin
                        r_md_state <= S_IDLE;
                        r_md_busy  <= 1'b0;
                    end else begin
                        r_md_cnt <= r_md_cnt - 8'd1;
                    end
                end
                default: begin
                    r_md_state <= S_IDLE;
                    r_md_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hs.stall_dec     = w_stall;
    assign hs.md_start      = r_md_start;
    assign hs.md_busy       = r_md_busy;
    assign hs.pending_count = w_pending_count;
endmodule

// File: tb/tb_hazard_scheduler.sv
// Randomized and directed bench for hazard_scheduler against a per-register/counter reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// The model tracks outstanding writers and MD cycles remaining rather than FSM state.
module tb_hazard_scheduler;
    localparam int NREG   = 16;
    localparam int MD_LAT = 4;
    localparam logic [1:0] EX_ALU = 2'd0;
    localparam logic [1:0] EX_MEM = 2'd1;
    localparam logic [1:0] EX_MD  = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_scheduler_if #(.PREG_COUNT(NREG)) hs ();

    hazard_scheduler #(
        .PREG_COUNT(NREG),
        .MD_LATENCY(MD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hs (hs)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which registers have an outstanding long-latency writer,
    // how many MD busy cycles remain, and whether md_start should be showing.
    bit m_pend[NREG];
    int m_left;
    bit m_start;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        m_left  = 0;
        m_start = 1'b0;
    endtask

    task automatic clear_in();
        hs.dec_valid      = 1'b0;
        hs.dec_rs_enable  = 1'b0;
        hs.dec_rt_enable  = 1'b0;
        hs.dec_prs_addr   = '0;
        hs.dec_prt_addr   = '0;
        hs.dec_wb_reg     = 1'b0;
        hs.dec_write_addr = '0;
        hs.dec_exec_src   = EX_ALU;
        hs.wb_wb_reg      = 1'b0;
        hs.wb_write_addr  = '0;
        hs.flush          = 1'b0;
    endtask

    task automatic set_dec(input bit v, input bit rs_en, input int rs, input bit rt_en, input int rt,
                           input bit wbr, input int wa, input logic [1:0] src);
        hs.dec_valid      = v;
        hs.dec_rs_enable  = rs_en;
        hs.dec_prs_addr   = 4'(rs);
        hs.dec_rt_enable  = rt_en;
        hs.dec_prt_addr   = 4'(rt);
        hs.dec_wb_reg     = wbr;
        hs.dec_write_addr = 4'(wa);
        hs.dec_exec_src   = src;
    endtask

    task automatic set_wb(input bit en, input int a);
        hs.wb_wb_reg     = en;
        hs.wb_write_addr = 4'(a);
    endtask

    // Called at a falling edge with inputs applied: check outputs, then advance the model
    // across the rising edge and return at the next falling edge.
    task automatic do_cycle();
        bit e_stall, e_issue, rs_hz, rt_hz, md_hz;
        int wa;
        #1;
        rs_hz = hs.dec_rs_enable && m_pend[hs.dec_prs_addr] &&
                !(hs.wb_wb_reg && hs.wb_write_addr == hs.dec_prs_addr);
        rt_hz = hs.dec_rt_enable && m_pend[hs.dec_prt_addr] &&
                !(hs.wb_wb_reg && hs.wb_write_addr == hs.dec_prt_addr);
        md_hz = (hs.dec_exec_src == EX_MD) && (m_left > 0);
        e_stall = hs.dec_valid && !hs.flush && (rs_hz || rt_hz || md_hz);
        e_issue = hs.dec_valid && !e_stall && !hs.flush;
        check("stall_dec", int'(hs.stall_dec), int'(e_stall));
        check("md_start", int'(hs.md_start), int'(m_start));
        check("md_busy", int'(hs.md_busy), int'(m_left > 0));
        check("pending_count", int'(hs.pending_count), m_count());
        @(posedge clk);
        wa = int'(hs.dec_write_addr);
        if (hs.wb_wb_reg) m_pend[hs.wb_write_addr] = 1'b0;
        if (e_issue && hs.dec_wb_reg && wa != 0 &&
            (hs.dec_exec_src == EX_MEM || hs.dec_exec_src == EX_MD))
            m_pend[wa] = 1'b1;
        if (e_issue && hs.dec_exec_src == EX_MD) begin
            m_left  = MD_LAT;
            m_start = 1'b1;
        end else begin
            m_start = 1'b0;
            if (m_left > 0) m_left--;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        clear_in();
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        m_reset();
        #3;
        check("rst_busy", int'(hs.md_busy), 0);
        check("rst_start", int'(hs.md_start), 0);
        check("rst_cnt", int'(hs.pending_count), 0);
        check("rst_stall", int'(hs.stall_dec), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Load to p5, then an ALU reader of p5 stalls until p5 retires.
        set_dec(1, 0, 0, 0, 0, 1, 5, EX_MEM);
        do_cycle();
        set_dec(1, 1, 5, 0, 0, 1, 6, EX_ALU);
        #1;
        check("r34_stall", int'(hs.stall_dec), 1);
        check("r34_cnt1", int'(hs.pending_count), 1);
        do_cycle();
        do_cycle();
        set_wb(1, 5);
        #1;
        check("r34_wb_stall", int'(hs.stall_dec), 0);
        do_cycle();
        clear_in();
        #1;
        check("r34_cnt0", int'(hs.pending_count), 0);
        do_cycle();

        // ALU writer of p7 never enters the scoreboard.
        set_dec(1, 0, 0, 0, 0, 1, 7, EX_ALU);
        do_cycle();
        set_dec(1, 1, 7, 1, 7, 0, 0, EX_ALU);
        #1;
        check("r39_stall", int'(hs.stall_dec), 0);
        check("r39_cnt", int'(hs.pending_count), 0);
        do_cycle();

        // New load to p9 in the same cycle p9 retires keeps p9 pending.
        set_dec(1, 0, 0, 0, 0, 1, 9, EX_MEM);
        do_cycle();
        set_wb(1, 9);
        do_cycle();
        clear_in();
        #1;
        check("r36_cnt", int'(hs.pending_count), 1);
        do_cycle();
        set_wb(1, 9);
        do_cycle();

        // Flush on a hazardous MD instruction: no stall, no set, MD stays idle.
        set_dec(1, 0, 0, 0, 0, 1, 3, EX_MEM);
        do_cycle();
        set_dec(1, 1, 3, 0, 0, 1, 4, EX_MD);
        hs.flush = 1'b1;
        #1;
        check("r37_stall", int'(hs.stall_dec), 0);
        do_cycle();
        clear_in();
        #1;
        check("r37_busy", int'(hs.md_busy), 0);
        check("r37_start", int'(hs.md_start), 0);
        check("r37_cnt", int'(hs.pending_count), 1);
        set_wb(1, 3);
        do_cycle();

        // MD occupancy: second MD stalls for MD_LAT cycles and issues on the next.
        set_dec(1, 0, 0, 0, 0, 1, 10, EX_MD);
        do_cycle();
        set_dec(1, 0, 0, 0, 0, 1, 11, EX_MD);
        for (int i = 0; i < MD_LAT; i++) begin
            #1;
            check("r35_stall", int'(hs.stall_dec), 1);
            check("r35_busy", int'(hs.md_busy), 1);
            check("r35_start", int'(hs.md_start), (i == 0) ? 1 : 0);
            do_cycle();
        end
        #1;
        check("r35_issue", int'(hs.stall_dec), 0);
        check("r35_idle", int'(hs.md_busy), 0);
        do_cycle();
        clear_in();
        set_wb(1, 10);
        do_cycle();
        set_wb(1, 11);
        do_cycle();
        idle(MD_LAT + 1);

        // Reset in the middle of an MD operation with three pending registers.
        set_dec(1, 0, 0, 0, 0, 1, 1, EX_MEM);
        do_cycle();
        set_dec(1, 0, 0, 0, 0, 1, 2, EX_MEM);
        do_cycle();
        set_dec(1, 0, 0, 0, 0, 1, 3, EX_MD);
        do_cycle();
        clear_in();
        #2;
        rst = 1'b1;
        #1;
        check("r38_busy", int'(hs.md_busy), 0);
        check("r38_start", int'(hs.md_start), 0);
        check("r38_cnt", int'(hs.pending_count), 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        set_dec(1, 0, 0, 0, 0, 1, 12, EX_MD);
        #1;
        check("r38_md_nostall", int'(hs.stall_dec), 0);
        do_cycle();
        idle(MD_LAT + 1);
        set_wb(1, 12);
        do_cycle();
        clear_in();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int start, wa;
            set_dec(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, NREG - 1),
                    $urandom_range(0, 1), $urandom_range(0, NREG - 1), $urandom_range(0, 1),
                    $urandom_range(0, NREG - 1), 2'($urandom_range(0, 2)));
            hs.flush = ($urandom_range(0, 9) == 0);
            start = $urandom_range(0, NREG - 1);
            wa = start;
            for (int k = 0; k < NREG; k++) begin
                if (m_pend[(start + k) % NREG]) begin
                    wa = (start + k) % NREG;
                    break;
                end
            end
            set_wb(($urandom_range(0, 2) != 0), wa);
            do_cycle();
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
